ram_burst: RTL

- Next-generation clocked RAM for the DMA datapath, replacing the asynchronous addr/w_notr/data RAM.
- Keeps the shared bidirectional data bus and w_notr direction convention.
- Adds a req/ack handshake, a parametrised access latency (wait states) and multi-word bursts with address auto-increment and wrap.
- Sits between the DMA engine and the memory-side bus; the bus master sees a deterministic beat schedule.

---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_array.sv | 33 +++
 rtl/ram_burst.sv | 116 +++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared state encoding and default parameters for ram_burst
//
// Purpose: burst RAM FSM state type plus the default geometry/latency set,
//          shared with the DMA engine so both sides agree on the beat schedule.
// Ports:   none (package).

package ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2
  } state_t;

  localparam int DEF_SZ      = 8;  // address width
  localparam int DEF_WSZ     = 8;  // word width
  localparam int DEF_BLW     = 4;  // burst-length field width
  localparam int DEF_LATENCY = 2;  // wait states before the first beat

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - storage array with async read port and sync write port
//
// Purpose: plain word storage; contents are never cleared.
// Ports:   clk   - write clock
//          we    - write enable, sampled at rising edge
//          waddr - write address
//          wdata - write data
//          raddr - read address (combinational read)
//          rdata - read data

module ram_array #(
  parameter int SZ  = 8,
  parameter int WSZ = 8
) (
  input  logic           clk,
  input  logic           we,
  input  logic [SZ-1:0]  waddr,
  input  logic [WSZ-1:0] wdata,
  input  logic [SZ-1:0]  raddr,
  output logic [WSZ-1:0] rdata
);

  logic [WSZ-1:0] mem [2**SZ];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_burst.sv
// rtl/ram_burst.sv - clocked burst RAM with req/ack handshake and wait states
//
// Purpose: accepts a burst request in IDLE, waits LATENCY cycles, then moves
//          burst_len+1 words, one per cycle, with address auto-increment/wrap.
// Ports:   clk       - system clock
//          rst_n     - synchronous active-low reset (memory is preserved)
//          req       - transfer request, sampled only in IDLE
//          w_notr    - 1 = write burst, 0 = read burst
//          addr      - burst start address
//          burst_len - number of beats minus one
//          data      - shared bidirectional data bus
//          ack       - high on every data beat
//          busy      - high whenever not IDLE
//          done      - high on the final beat

module ram_burst
  import ram_pkg::*;
#(
  parameter int SZ      = DEF_SZ,
  parameter int WSZ     = DEF_WSZ,
  parameter int BLW     = DEF_BLW,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req,
  input  logic           w_notr,
  input  logic [SZ-1:0]  addr,
  input  logic [BLW-1:0] burst_len,
  inout  wire  [WSZ-1:0] data,
  output logic           ack,
  output logic           busy,
  output logic           done
);

  // Wait counter only needs to hold LATENCY; keep at least one bit.
  localparam int WCW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

  state_t         state, state_nxt;
  logic [SZ-1:0]  cur_addr;
  logic           dir;
  logic [BLW-1:0] beats_left;
  logic [WCW-1:0] wcnt;
  logic [WSZ-1:0] rdata;
  logic           we;
  logic           rd_drive;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = (LATENCY > 0) ? WAIT : XFER;
      WAIT: if (wcnt == WCW'(1)) state_nxt = XFER;
      XFER: if (beats_left == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst context is captured on accept so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_addr   <= '0;
      dir        <= 1'b0;
      beats_left <= '0;
      wcnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cur_addr   <= addr;
            dir        <= w_notr;
            beats_left <= burst_len;
            wcnt       <= WCW'(LATENCY);
          end
        end
        WAIT: wcnt <= wcnt - WCW'(1);
        XFER: begin
          cur_addr   <= cur_addr + SZ'(1);  // wraps modulo 2**SZ
          beats_left <= beats_left - BLW'(1);
        end
        default: ;
      endcase
    end
  end

  // All handshake outputs come from registered state only.
  assign ack  = (state == XFER);
  assign busy = (state != IDLE);
  assign done = ack && (beats_left == '0);

  // A reset arriving on a write beat aborts that beat as well.
  assign we       = ack && dir && rst_n;
  assign rd_drive = ack && !dir;

  assign data = rd_drive ? rdata : {WSZ{1'bz}};

  ram_array #(
    .SZ  (SZ),
    .WSZ (WSZ)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (cur_addr),
    .wdata (data),
    .raddr (cur_addr),
    .rdata (rdata)
  );

endmodule
